// File: rtl/gf_mul_arbiter.sv
// Shared GF(2^8) multiply / inverse engine (AES polynomial 0x11B) with a
// round-robin front end. One log ROM and one antilog ROM are time-shared by
// all requesters; the FSM does one lookup of each kind per cycle at most.
//
// state  | meaning
// IDLE   | arbiter offers a grant, operands captured on accept
// LOGA   | la <- log[a]
// LOGB   | lb <- log[b] (multiply only)
// EXP    | res_data <- exp[(la+lb) mod 255] or exp[255-la]
// DONE   | result presented, held until res_ready
module gf_mul_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDW-1:0]    res_id,
  output logic [7:0]        res_data,
  output logic              busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOGA, S_LOGB, S_EXP, S_DONE} state_t;

  function automatic logic [7:0] mul3(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00) ^ v;
  endfunction

  // Antilog table: e(i) = 3^i, which naturally wraps to e(255) = 0x01.
  function automatic logic [2047:0] gen_exp();
    logic [2047:0] t;
    logic [7:0]    v;
    t = '0;
    v = 8'h01;
    for (int i = 0; i < 256; i++) begin
      t[i*8 +: 8] = v;
      v = mul3(v);
    end
    return t;
  endfunction

  // Log table: inverse of the antilog over 0..254; entry 0 is never read.
  function automatic logic [2047:0] gen_log();
    logic [2047:0] t;
    logic [7:0]    v;
    t = '0;
    v = 8'h01;
    for (int i = 0; i < 255; i++) begin
      t[v*8 +: 8] = i[7:0];
      v = mul3(v);
    end
    return t;
  endfunction

  localparam logic [2047:0] EXP_ROM = gen_exp();
  localparam logic [2047:0] LOG_ROM = gen_log();

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             op_q, op_d;
  logic [7:0]       a_q, a_d, b_q, b_d;
  logic [7:0]       la_q, la_d, lb_q, lb_d;
  logic [7:0]       res_data_q, res_data_d;

  logic             grant_found;
  logic [IDW-1:0]   grant_idx;
  logic             grant_op;
  logic [7:0]       grant_a, grant_b;
  logic [7:0]       log_addr, log_val, exp_idx, exp_val;
  logic [8:0]       sum9;

  // Round-robin search starting at rr_ptr and wrapping.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_id;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_id     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = IDW'(cand);
      if (!grant_found && req_valid[cand_id]) begin
        grant_found = 1'b1;
        grant_idx   = cand_id;
      end
    end
  end

  // One-hot grant, only offered in IDLE and never while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Next-state, operand capture and ROM lookups.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    la_d       = la_q;
    lb_d       = lb_q;
    res_data_d = res_data_q;

    grant_op = req_op[grant_idx];
    grant_a  = req_a[{grant_idx, 3'b000} +: 8];
    grant_b  = req_b[{grant_idx, 3'b000} +: 8];

    log_addr = (state_q == S_LOGB) ? b_q : a_q;
    log_val  = LOG_ROM[{log_addr, 3'b000} +: 8];

    sum9 = {1'b0, la_q} + {1'b0, lb_q};
    if (op_q)                exp_idx = 8'd255 - la_q;
    else if (sum9 >= 9'd255) exp_idx = 8'(sum9 - 9'd255);
    else                     exp_idx = sum9[7:0];
    exp_val = EXP_ROM[{exp_idx, 3'b000} +: 8];

    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          id_d     = grant_idx;
          op_d     = grant_op;
          a_d      = grant_a;
          b_d      = grant_b;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          if (grant_a == 8'h00 || (!grant_op && grant_b == 8'h00)) begin
            res_data_d = 8'h00;
            state_d    = S_DONE;
          end else begin
            state_d = S_LOGA;
          end
        end
      end
      S_LOGA: begin
        la_d    = log_val;
        state_d = op_q ? S_EXP : S_LOGB;
      end
      S_LOGB: begin
        lb_d    = log_val;
        state_d = S_EXP;
      end
      S_EXP: begin
        res_data_d = exp_val;
        state_d    = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      op_q       <= 1'b0;
      a_q        <= 8'h00;
      b_q        <= 8'h00;
      la_q       <= 8'h00;
      lb_q       <= 8'h00;
      res_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      la_q       <= la_d;
      lb_q       <= lb_d;
      res_data_q <= res_data_d;
    end
  end

  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_id    = id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_gf_mul_arbiter.sv
// Randomized bench for gf_mul_arbiter against a shift-and-xor GF(2^8) model.
module tb_gf_mul_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready, req_op;
  logic [NREQ*8-1:0] req_a, req_b;
  logic              res_valid, res_ready, busy;
  logic [IDW-1:0]    res_id;
  logic [7:0]        res_data;

  int n_checks = 0;
  int n_fail   = 0;

  gf_mul_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int x = 1; x < 256; x++)
      if (gmul(a, 8'(x)) == 8'h01) return 8'(x);
    return 8'h00;
  endfunction

  function automatic logic [7:0] model(input logic op, input logic [7:0] a, input logic [7:0] b);
    return op ? ginv(a) : gmul(a, b);
  endfunction

  function automatic int model_lat(input logic op, input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || (!op && b == 8'h00)) return 1;
    return op ? 3 : 4;
  endfunction

  // Single request from requester r; checks result, owner and accept-to-valid latency.
  task automatic run_op(input int r, input logic op, input logic [7:0] a, input logic [7:0] b);
    int n;
    int lat;
    @(negedge clk);
    req_op[r] = op;
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_valid[r] = 1'b1;
    n = 0;
    while (!req_ready[r] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[r]) begin
      check("grant_timeout", 32'(req_ready), 32'(1 << r));
      req_valid[r] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 10);
    check($sformatf("lat op=%0d a=%02h b=%02h", op, a, b), 32'(lat), 32'(model_lat(op, a, b)));
    check($sformatf("data op=%0d a=%02h b=%02h", op, a, b), 32'(res_data), 32'(model(op, a, b)));
    check("res_id", 32'(res_id), 32'(r));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    logic [7:0] held_d;
    logic       rop;
    logic [7:0] ra, rb;

    rst_n = 1'b0; res_ready = 1'b1;
    req_valid = 2'b01; req_op = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", 32'(res_data), 32'h0);
    check("rst_res_id", 32'(res_id), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_req_ready", 32'(req_ready), 32'h0);

    // Directed cases, including the la=0 and mod-255 wrap boundaries.
    run_op(0, 1'b0, 8'h57, 8'h83);
    check("mul_57_83_const", 32'(res_data), 32'hC1);
    run_op(0, 1'b0, 8'h02, 8'h87);
    check("mul_02_87_const", 32'(res_data), 32'h15);
    run_op(1, 1'b1, 8'h53, 8'h00);
    check("inv_53_const", 32'(res_data), 32'hCA);
    run_op(1, 1'b1, 8'h01, 8'h77);
    run_op(1, 1'b1, 8'h00, 8'h12);
    run_op(0, 1'b0, 8'hF6, 8'hF6);
    run_op(0, 1'b0, 8'h00, 8'h35);
    run_op(1, 1'b0, 8'h35, 8'h00);
    run_op(0, 1'b0, 8'h01, 8'h01);
    run_op(0, 1'b0, 8'hFF, 8'hFF);

    // Every inverse.
    for (int i = 0; i < 256; i++) run_op(i % 2, 1'b1, 8'(i), 8'($urandom));

    // Random multiplies and inverses with some forced zeros.
    for (int i = 0; i < 1500; i++) begin
      rop = ($urandom_range(0, 3) == 0);
      ra  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      rb  = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      run_op($urandom_range(0, 1), rop, ra, rb);
    end

    // Round-robin: both requesters held valid after reset, expect 0,1,0,1.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_op = 2'b10;
    req_a = {8'h53, 8'h57};
    req_b = {8'h00, 8'h83};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!res_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rr_id_%0d", k), 32'(res_id), 32'(k % 2));
      check($sformatf("rr_data_%0d", k), 32'(res_data),
            32'((k % 2) ? model(1'b1, 8'h53, 8'h00) : model(1'b0, 8'h57, 8'h83)));
      @(posedge clk);
      #1;
      if (k == 3) req_valid = 2'b00;
    end

    // Backpressure: result and owner held, no grant while DONE is stalled.
    res_ready = 1'b0;
    @(negedge clk);
    req_op = 2'b10;
    req_a = {8'h53, 8'h02};
    req_b = {8'h00, 8'h87};
    req_valid = 2'b01;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 2'b10;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    held_d = gmul(8'h02, 8'h87);
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 32'(res_valid), 32'h1);
      check("bp_data", 32'(res_data), 32'(held_d));
      check("bp_id", 32'(res_id), 32'h0);
      check("bp_no_grant", 32'(req_ready), 32'h0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_next_grant", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1 req_valid = 2'b00;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp_next_data", 32'(res_data), 32'(ginv(8'h53)));
    check("bp_next_id", 32'(res_id), 32'h1);
    @(posedge clk);
    #1;

    // Abort in LOGB: no result, back to IDLE with rr_ptr cleared.
    @(negedge clk);
    req_op = 2'b00;
    req_a = {8'h00, 8'h57};
    req_b = {8'h00, 8'h83};
    req_valid = 2'b01;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_valid", 32'(res_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("abort_no_result", 32'(res_valid), 32'h0);
    end
    req_a = {8'h53, 8'h57};
    req_valid = 2'b11;
    #1;
    check("abort_rr_ptr0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
